myo_spi_scheduler: RTL

- Time-multiplexes one shared SpiControl and SPI master across up to NUMBER_OF_MOTORS myo motor boards.
- Generates the periodic update tick and walks the enabled motors in ascending index order each round.
- Drives motor_select, which steers the ss_n/MISO mux and the pwmRef source, and pulses start into SpiControl.
- Sits between the register/Avalon bank and the SpiControl instance; watches spi_done for completion and timeouts.

---
 rtl/myo_spi_scheduler.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/myo_spi_scheduler.sv
// myo_spi_scheduler
//   Time-multiplexes one SpiControl / SPI master across NUMBER_OF_MOTORS myo
//   motor boards. A free-running period timer raises a tick every
//   UPDATE_PERIOD cycles. Each tick starts a round that walks the enabled
//   motors in ascending order: select the motor, let the ss_n/MISO mux
//   settle, pulse start, then follow spi_done through the frame.
//
// Ports
//   clock          in   system clock
//   reset          in   asynchronous, active-high reset
//   enable         in   run rounds while high
//   motor_mask     in   bit i set = motor i serviced (latched at round start)
//   spi_done       in   SpiControl idle / frame finished
//   error_clear    in   pulse: clears timeout_error and overrun
//   start          out  one-cycle start pulse to SpiControl
//   motor_select   out  active motor index (mux / pwmRef steering)
//   busy           out  round in progress
//   cycle_done     out  one-cycle pulse at the end of each round
//   timeout_error  out  sticky per-motor ack/frame timeout flags
//   overrun        out  sticky: tick arrived while busy
//   round_count    out  completed rounds, wraps at 2^32
module myo_spi_scheduler #(
   parameter int NUMBER_OF_MOTORS = 6,
   parameter int MOTOR_BITS       = 4,
   parameter int UPDATE_PERIOD    = 50000,
   parameter int SETTLE_CYCLES    = 4,
   parameter int ACK_TIMEOUT      = 64,
   parameter int FRAME_TIMEOUT    = 4096
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [NUMBER_OF_MOTORS-1:0] motor_mask,
   input  logic                        spi_done,
   input  logic                        error_clear,
   output logic                        start,
   output logic [MOTOR_BITS-1:0]       motor_select,
   output logic                        busy,
   output logic                        cycle_done,
   output logic [NUMBER_OF_MOTORS-1:0] timeout_error,
   output logic                        overrun,
   output logic [31:0]                 round_count
);

   localparam int PW   = ($clog2(UPDATE_PERIOD) > 0) ? $clog2(UPDATE_PERIOD) : 1;
   localparam int SW   = ($clog2(SETTLE_CYCLES + 1) > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam int TMAX = (ACK_TIMEOUT > FRAME_TIMEOUT) ? ACK_TIMEOUT : FRAME_TIMEOUT;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int PTW  = MOTOR_BITS + 1;

   localparam logic [PW-1:0]  PERIOD_LAST = PW'(UPDATE_PERIOD - 1);
   localparam logic [SW-1:0]  SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [TW-1:0]  ACK_LAST    = TW'(ACK_TIMEOUT - 1);
   localparam logic [TW-1:0]  FRAME_LAST  = TW'(FRAME_TIMEOUT - 1);
   localparam logic [PTW-1:0] PTR_END     = PTW'(NUMBER_OF_MOTORS);

   typedef enum logic [3:0] {
      S_IDLE, S_WAIT_PERIOD, S_SCAN, S_SETTLE, S_START,
      S_WAIT_ACK, S_WAIT_DONE, S_NEXT, S_ROUND_END
   } state_t;

   state_t                      state_q;
   logic [PW-1:0]               timer_q;
   logic                        tick_q;
   logic [NUMBER_OF_MOTORS-1:0] mask_q;
   logic [PTW-1:0]              ptr_q;
   logic [SW-1:0]               settle_q;
   logic [TW-1:0]               tmo_q;
   logic                        start_q, busy_q, cd_q, ovr_q;
   logic [MOTOR_BITS-1:0]       ms_q;
   logic [NUMBER_OF_MOTORS-1:0] err_q;
   logic [31:0]                 rc_q;

   logic                        found;
   logic [MOTOR_BITS-1:0]       found_idx;
   logic [PTW-1:0]              nxt_ptr;
   logic [NUMBER_OF_MOTORS-1:0] err_sel;
   logic [NUMBER_OF_MOTORS-1:0] err_base;

   // Lowest enabled motor at or above the pointer: scanning downward lets the
   // last hit be the lowest index.
   always_comb begin
      found     = 1'b0;
      found_idx = '0;
      for (int unsigned i = NUMBER_OF_MOTORS; i > 0; i--) begin
         if (mask_q[i-1] && ((i - 1) >= 32'(ptr_q))) begin
            found     = 1'b1;
            found_idx = MOTOR_BITS'(i - 1);
         end
      end
   end

   always_comb begin
      nxt_ptr = PTW'(ms_q) + PTW'(1);
      err_sel = '0;
      for (int unsigned i = 0; i < NUMBER_OF_MOTORS; i++) begin
         if (MOTOR_BITS'(i) == ms_q) err_sel[i] = 1'b1;
      end
      // A new timeout in the same cycle as error_clear keeps its bit.
      err_base = error_clear ? '0 : err_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         tick_q   <= 1'b0;
         mask_q   <= '0;
         ptr_q    <= '0;
         settle_q <= '0;
         tmo_q    <= '0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         cd_q     <= 1'b0;
         ovr_q    <= 1'b0;
         ms_q     <= '0;
         err_q    <= '0;
         rc_q     <= '0;
      end else begin
         start_q <= 1'b0;
         cd_q    <= 1'b0;
         // busy drops together with the end of the cycle_done pulse; a round
         // starting in that same cycle re-asserts it below.
         if (cd_q) busy_q <= 1'b0;
         if (error_clear) begin
            err_q <= '0;
            ovr_q <= 1'b0;
         end
         if (tmo_q != '1) tmo_q <= tmo_q + TW'(1);

         case (state_q)
            S_IDLE: if (enable) state_q <= S_WAIT_PERIOD;
            S_WAIT_PERIOD: begin
               if (!enable) begin
                  state_q <= S_IDLE;
               end else if (tick_q) begin
                  tick_q  <= 1'b0;
                  mask_q  <= motor_mask;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_SCAN;
               end
            end
            S_SCAN: begin
               tmo_q <= '0;
               if (found) begin
                  ms_q     <= found_idx;
                  settle_q <= '0;
                  state_q  <= (SETTLE_CYCLES == 0) ? S_START : S_SETTLE;
               end else begin
                  state_q <= S_ROUND_END;
               end
            end
            S_SETTLE: begin
               tmo_q <= '0;
               if (settle_q == SETTLE_LAST) state_q  <= S_START;
               else                         settle_q <= settle_q + SW'(1);
            end
            S_START: begin
               if (spi_done) begin
                  start_q <= 1'b1;
                  state_q <= S_WAIT_ACK;
               end
            end
            S_WAIT_ACK: begin
               if (!spi_done) begin
                  tmo_q   <= '0;
                  state_q <= S_WAIT_DONE;
               end else if (tmo_q >= ACK_LAST) begin
                  err_q   <= err_base | err_sel;
                  state_q <= S_NEXT;
               end
            end
            S_WAIT_DONE: begin
               if (spi_done) begin
                  state_q <= S_NEXT;
               end else if (tmo_q >= FRAME_LAST) begin
                  err_q   <= err_base | err_sel;
                  state_q <= S_NEXT;
               end
            end
            S_NEXT: begin
               ptr_q   <= nxt_ptr;
               state_q <= (nxt_ptr == PTR_END) ? S_ROUND_END : S_SCAN;
            end
            S_ROUND_END: begin
               cd_q    <= 1'b1;
               rc_q    <= rc_q + 32'd1;
               state_q <= enable ? S_WAIT_PERIOD : S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase

         // Period timer is evaluated after the FSM so a wrap in the same cycle
         // as tick consumption leaves the new tick pending.
         if (!enable) begin
            timer_q <= '0;
            tick_q  <= 1'b0;
         end else if (timer_q == PERIOD_LAST) begin
            timer_q <= '0;
            tick_q  <= 1'b1;
            if (busy_q) ovr_q <= 1'b1;
         end else begin
            timer_q <= timer_q + PW'(1);
         end
      end
   end

   assign start         = start_q;
   assign motor_select  = ms_q;
   assign busy          = busy_q;
   assign cycle_done    = cd_q;
   assign timeout_error = err_q;
   assign overrun       = ovr_q;
   assign round_count   = rc_q;

endmodule
